// File: rtl/debug_display_scanner_if.sv
// Signal bundle between the debug-board display scanner and whatever drives it
// (debug words, paging/step buttons in; segments, anodes, step pulse, page out).
interface debug_display_scanner_if #(
    parameter int DIGITS = 4,
    parameter int WORD_W = 32
);
    localparam int NPAGES = WORD_W / (4 * DIGITS);
    localparam int PAGE_W = (NPAGES > 1) ? $clog2(NPAGES) : 1;

    logic [WORD_W-1:0] word_a;
    logic [WORD_W-1:0] word_b;
    logic              src_sel;
    logic              auto_page;
    logic              page_btn;
    logic              step_btn;
    logic [DIGITS-1:0] blank;
    logic [6:0]        seg;
    logic [DIGITS-1:0] anode;
    logic              step_pulse;
    logic [PAGE_W-1:0] page;

    modport master (
        output word_a, word_b, src_sel, auto_page, page_btn, step_btn, blank,
        input  seg, anode, step_pulse, page
    );

    modport slave (
        input  word_a, word_b, src_sel, auto_page, page_btn, step_btn, blank,
        output seg, anode, step_pulse, page
    );
endinterface

// File: rtl/debug_display_scanner.sv
// Multiplexed hex display of a paged debug word on a common-anode 7-seg display,
// plus button debouncers producing page-advance and single-step press pulses.
module debug_display_scanner_debounce #(
    parameter int CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [1:0]    sync_q;
    logic [1:0]    vld_q;
    logic          level_q, level_d;
    logic          armed_q, armed_d;
    logic          press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // A press only counts once a real released sample has been seen since reset,
    // so a button held through reset never produces a pulse.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        armed_d = armed_q | (vld_q[1] & ~sync_q[1]);
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(CYCLES - 1)) level_d = ~level_q;
            else                          cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            vld_q   <= '0;
            level_q <= 1'b0;
            armed_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            vld_q   <= {vld_q[0], 1'b1};
            level_q <= level_d;
            armed_q <= armed_d;
            press_q <= level_d & ~level_q & armed_q;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;
endmodule

module debug_display_scanner #(
    parameter int DIGITS          = 4,
    parameter int WORD_W          = 32,
    parameter int REFRESH_DIV     = 65536,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int PAGE_HOLD       = 50000000
) (
    input logic                     clk,
    input logic                     reset,
    debug_display_scanner_if.slave  bus
);
    localparam int NPAGES = WORD_W / (4 * DIGITS);
    localparam int PAGE_W = (NPAGES > 1) ? $clog2(NPAGES) : 1;
    localparam int RW     = $clog2(REFRESH_DIV);
    localparam int DW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TW     = $clog2(PAGE_HOLD);

    logic [1:0] press;

    debug_display_scanner_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db [1:0] (
        .clk     (clk),
        .reset   (reset),
        .btn_i   ({bus.step_btn, bus.page_btn}),
        .press_o (press)
    );

    logic [RW-1:0]     rcnt_q, rcnt_d;
    logic [DW-1:0]     dig_q, dig_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [PAGE_W-1:0] page_q, page_d;
    logic [DIGITS-1:0] blank_q, blank_d;
    logic [PAGE_W-1:0] pend_q, pend_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic              auto_q;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] anode_q, anode_d;
    logic              step_q;
    logic              rwrap, frame, pend_inc;
    logic [3:0]        nib;
    int                shamt;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        rwrap  = (rcnt_q == RW'(REFRESH_DIV - 1));
        frame  = rwrap && (dig_q == '0);
        rcnt_d = rwrap ? '0 : rcnt_q + 1'b1;
        dig_d  = dig_q;
        if (rwrap) dig_d = (dig_q == DW'(DIGITS - 1)) ? '0 : dig_q + 1'b1;

        // Mode change restarts the page timer; presses only act in manual mode.
        tmr_d    = tmr_q;
        pend_inc = ~bus.auto_page & press[0];
        if (bus.auto_page != auto_q) begin
            tmr_d = '0;
        end else if (bus.auto_page) begin
            if (tmr_q == TW'(PAGE_HOLD - 1)) begin
                tmr_d    = '0;
                pend_inc = 1'b1;
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
        end
        pend_d = pend_q;
        if (pend_inc) pend_d = (pend_q == PAGE_W'(NPAGES - 1)) ? '0 : pend_q + 1'b1;

        // The digit lit at frame start already uses the freshly captured snapshot.
        word_d  = word_q;
        page_d  = page_q;
        blank_d = blank_q;
        if (frame) begin
            word_d  = bus.src_sel ? bus.word_b : bus.word_a;
            page_d  = pend_d;
            blank_d = bus.blank;
        end

        shamt = ((NPAGES - 1 - int'(page_d)) * DIGITS + int'(dig_q)) * 4;
        nib   = 4'(word_d >> shamt);

        seg_d   = seg_q;
        anode_d = anode_q;
        if (rwrap) begin
            if (blank_d[dig_q]) begin
                seg_d   = '1;
                anode_d = '1;
            end else begin
                seg_d   = glyph(nib);
                anode_d = ~(DIGITS'(1) << dig_q);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rcnt_q  <= '0;
            dig_q   <= '0;
            word_q  <= '0;
            page_q  <= '0;
            blank_q <= '0;
            pend_q  <= '0;
            tmr_q   <= '0;
            auto_q  <= 1'b0;
            seg_q   <= '1;
            anode_q <= '1;
            step_q  <= 1'b0;
        end else begin
            rcnt_q  <= rcnt_d;
            dig_q   <= dig_d;
            word_q  <= word_d;
            page_q  <= page_d;
            blank_q <= blank_d;
            pend_q  <= pend_d;
            tmr_q   <= tmr_d;
            auto_q  <= bus.auto_page;
            seg_q   <= seg_d;
            anode_q <= anode_d;
            step_q  <= press[1];
        end
    end

    assign bus.seg        = seg_q;
    assign bus.anode      = anode_q;
    assign bus.step_pulse = step_q;
    assign bus.page       = page_q;
endmodule

// File: doc/debug_display_scanner.md
# debug_display_scanner

Parametrised multiplexed hex display controller for the single-cycle processor debug board. It shows a WORD_W-bit debug word on a DIGITS-wide common-anode seven-segment display. The word comes from one of two sources (register value or instruction machine code) and is split into pages that advance manually or automatically. It also debounces the raw single-step push button into a one-cycle step pulse for the processor. It replaces the fixed 4-digit, top/bottom-half display path.

## Interface
- DIGITS, 4, number of display digits (1..8)
- WORD_W, 32, debug word width; must be a multiple of 4*DIGITS
- REFRESH_DIV, 65536, clk cycles each digit stays lit (>=2)
- DEBOUNCE_CYCLES, 250000, consecutive stable samples required to accept a button level change (>=1)
- PAGE_HOLD, 50000000, clk cycles per page in auto mode (>=2)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; all state is cleared while low
- word_a  in  WORD_W  register-file debug value
- word_b  in  WORD_W  instruction machine-code value
- src_sel  in  1  0 selects word_a, 1 selects word_b
- auto_page  in  1  1 means pages advance on a timer; 0 means pages advance on page_btn
- page_btn  in  1  raw, bouncy page-advance button
- step_btn  in  1  raw, bouncy single-step button
- blank  in  DIGITS  bit i=1 forces digit i dark
- seg  out  7  segments, seg[0]=a … seg[6]=g, active-low
- anode  out  DIGITS  digit enables, active-low; anode[DIGITS-1] is the leftmost digit
- step_pulse  out  1  one-cycle pulse per accepted step_btn press
- page  out  clog2(NPAGES) (min 1)  page currently displayed

## Operation
- NPAGES = WORD_W/(4*DIGITS). Page p shows nibbles counted from the MSB. Page 0 is the most-significant 4*DIGITS bits.
- Digit i (anode[i]) shows nibble i of the page slice, with digit 0 holding the least-significant nibble.
- Scan: a refresh counter counts 0..REFRESH_DIV-1. On wrap, the digit index advances i→i+1 mod DIGITS.
- Frame start is the wrap of the digit index to 0. At frame start the block captures a snapshot of the source word selected by src_sel, plus the pending page value and the blank mask. The display never mixes two words within one frame.
- Glyphs: standard hex with active-low segments. Examples: 0→1000000… (in seg[0:6] order a..g: 0000001), 1→1001111, 8→0000000, A→0001000, F→0111000.
- Blanked digit: anode bit stays high and seg=all 1.
- Debouncers (two identical instances, one for page_btn and one for step_btn):
  - 2-flop synchroniser, then a stable counter.
  - The debounced level flips after DEBOUNCE_CYCLES consecutive synchronised samples that differ from it.
  - Any sample equal to the debounced level clears the counter.
- A debounced 0→1 transition produces a one-cycle press pulse. Releases produce nothing.
- step_pulse is the step-button press pulse, registered.
- Manual mode (auto_page=0): a page press increments the pending page mod NPAGES.
- Auto mode (auto_page=1): the page timer counts 0..PAGE_HOLD-1. On wrap, the pending page increments mod NPAGES. Page presses are ignored.
- Any change of auto_page clears the page timer. The pending page is retained.
- The page output shows the committed (frame-start) page.
- NPAGES=1: page stays 0 and presses have no effect.

## Timing
- Reset (reset low) values:
  - seg=all 1, anode=all 1, step_pulse=0, page=0.
  - Refresh counter, digit index, debouncers (level 0), page timer and snapshot all 0.
- After reset deasserts, digit 0 lights at the first refresh wrap, REFRESH_DIV cycles later. It shows the word sampled at that edge. seg and anode change on the same edge.
- seg and anode are registered and always consistent: exactly one anode is low unless the digit is blanked.
- Step latency: a raw rise first sampled at edge k gives step_pulse high for exactly the cycle after edge k+2+DEBOUNCE_CYCLES, provided the input is stable.
- Bounce shorter than DEBOUNCE_CYCLES produces no pulse. Holding the button produces exactly one pulse.
- Source, page and blank changes become visible at the next frame start. Worst case is DIGITS*REFRESH_DIV cycles.
- A page press and an auto-timer wrap in the same cycle cannot both act, because the mode is exclusive.
- If a frame start coincides with a page increment, the new page is committed at that frame start.
- reset low mid-press or mid-frame clears everything immediately and asynchronously. No step_pulse is generated on exit from reset, even if step_btn is held high; the level must first be debounced to 1 and a fresh 0→1 is required.

## Test plan
Parameters for all scenarios: DIGITS=4, WORD_W=32, REFRESH_DIV=4, DEBOUNCE_CYCLES=3, PAGE_HOLD=64.
- Reset: hold reset low with random inputs → seg=1111111, anode=1111, step_pulse=0, page=0. Release → first anode=1110 appears 4 cycles later.
- Scan: word_a=0x1234ABCD, src_sel=0, page 0 → anode sequence 1110,1101,1011,0111 each for 4 cycles, with glyphs 4,3,2,1. After one page press the glyphs are D,C,B,A.
- Debounce: step_btn toggles 1,0,1,0 at 1-cycle spacing, then steady 1 → exactly one step_pulse, 6 cycles after the steady rise is first sampled. A 2-cycle glitch gives no pulse.
- Auto paging: auto_page=1 → page toggles 0→1→0 every 64 cycles. page_btn presses are ignored. Switching to manual and back restarts the 64-cycle count.
- Frame coherency: change src_sel mid-frame (word_b=0xFFFF0000) → remaining digits of the current frame still show word_a. The next frame shows 0,0,0,0 on page 1.
- Blank: blank=0101 → anode[0] and anode[2] never low and seg=1111111 during their slots. Other digits are unaffected.
